// File: rtl/adder2_pkg.sv
// Shared constants for the branch-target adder: default data width and the
// width of the carry-extended sum.
package adder2_pkg;

  localparam int unsigned WIDTH_DEF  = 6;
  localparam int unsigned RESULT_DEF = WIDTH_DEF + 1;

endpackage

// File: rtl/adder_2_if.sv
// Operand/result bundle for adder_2: the master drives operands and select,
// the slave returns the registered next address.
interface adder_2_if
  import adder2_pkg::*;
#(
  parameter int unsigned WIDTH = WIDTH_DEF
);

  logic             in_valid;
  logic [WIDTH-1:0] in_buf1_adder1;
  logic [WIDTH-1:0] in_shft;
  logic             in_and;
  logic [WIDTH-1:0] out_m6;
  logic             out_valid;
  logic             out_carry;

  modport master (
    output in_valid,
    output in_buf1_adder1,
    output in_shft,
    output in_and,
    input  out_m6,
    input  out_valid,
    input  out_carry
  );

  modport slave (
    input  in_valid,
    input  in_buf1_adder1,
    input  in_shft,
    input  in_and,
    output out_m6,
    output out_valid,
    output out_carry
  );

endinterface

// File: rtl/adder_2_core.sv
// Purely combinational unsigned ripple-carry adder with carry-out.
module adder_2_core
  import adder2_pkg::*;
#(
  parameter int unsigned WIDTH = WIDTH_DEF
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);

  logic carry;

  // Carry is walked bit by bit through a single variable so the chain stays
  // a true ripple structure without a self-referencing vector.
  always_comb begin
    sum   = '0;
    carry = 1'b0;
    for (int i = 0; i < int'(WIDTH); i++) begin
      sum[i] = a[i] ^ b[i] ^ carry;
      carry  = (a[i] & b[i]) | (carry & (a[i] ^ b[i]));
    end
    cout = carry;
  end

endmodule

// File: rtl/adder_2.sv
// Next-address stage: selects PC+offset (branch taken) or PC pass-through and
// registers the result with a one-cycle latency.
module adder_2
  import adder2_pkg::*;
#(
  parameter int unsigned WIDTH = WIDTH_DEF
) (
  input  logic       clk,
  input  logic       rst_n,
  adder_2_if.slave   bus
);

  logic [WIDTH-1:0] core_sum;
  logic             core_cout;
  logic [WIDTH:0]   result;

  logic [WIDTH-1:0] m6_d, m6_q;
  logic             carry_d, carry_q;
  logic             valid_q;

  adder_2_core #(
    .WIDTH (WIDTH)
  ) u_core (
    .a    (bus.in_buf1_adder1),
    .b    (bus.in_shft),
    .sum  (core_sum),
    .cout (core_cout)
  );

  // Not-taken branches pass the base through and never report a carry.
  always_comb begin
    result = {1'b0, bus.in_buf1_adder1};
    if (bus.in_and) begin
      result = {core_cout, core_sum};
    end
  end

  always_comb begin
    m6_d    = m6_q;
    carry_d = carry_q;
    if (bus.in_valid) begin
      m6_d    = result[WIDTH-1:0];
      carry_d = result[WIDTH];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m6_q    <= '0;
      carry_q <= 1'b0;
      valid_q <= 1'b0;
    end else begin
      m6_q    <= m6_d;
      carry_q <= carry_d;
      valid_q <= bus.in_valid;
    end
  end

  assign bus.out_m6    = m6_q;
  assign bus.out_carry = carry_q;
  assign bus.out_valid = valid_q;

endmodule

// File: tb/tb_adder_2.sv
// Directed bench for adder_2: expected results are queued as stimulus is
// driven and compared when the registered output appears.
module tb_adder_2;
  import adder2_pkg::*;

  localparam int unsigned W = WIDTH_DEF;

  typedef struct packed {
    logic [W-1:0] m6;
    logic         carry;
  } exp_t;

  logic clk;
  logic rst_n;
  int   checks;
  int   errors;
  exp_t sb_q[$];
  exp_t held;

  adder_2_if #(.WIDTH(W)) bus ();

  adder_2 #(
    .WIDTH (W)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One cycle: drive at negedge, sample 1 time unit after the next posedge.
  task automatic step(input logic v, input logic s, input logic [W-1:0] a,
                      input logic [W-1:0] b, input string tag);
    logic [W:0] full;
    exp_t       e;
    exp_t       got;
    @(negedge clk);
    bus.in_valid       = v;
    bus.in_and         = s;
    bus.in_buf1_adder1 = a;
    bus.in_shft        = b;
    if (v) begin
      full = s ? ({1'b0, a} + {1'b0, b}) : {1'b0, a};
      e.m6    = full[W-1:0];
      e.carry = full[W];
      sb_q.push_back(e);
    end
    @(posedge clk);
    #1;
    check({tag, " valid"}, 32'(bus.out_valid), 32'(v));
    if (bus.out_valid === 1'b1) begin
      if (sb_q.size() == 0) begin
        check({tag, " unexpected output"}, 32'(1), 32'(0));
      end else begin
        held = sb_q.pop_front();
      end
    end
    got.m6    = bus.out_m6;
    got.carry = bus.out_carry;
    check({tag, " m6"}, 32'(got.m6), 32'(held.m6));
    check({tag, " carry"}, 32'(got.carry), 32'(held.carry));
  endtask

  initial begin
    checks = 0;
    errors = 0;
    held   = '0;
    rst_n  = 1'b0;
    bus.in_valid       = 1'b0;
    bus.in_and         = 1'b0;
    bus.in_buf1_adder1 = '0;
    bus.in_shft        = '0;

    #3;
    check("reset m6", 32'(bus.out_m6), 32'(0));
    check("reset carry", 32'(bus.out_carry), 32'(0));
    check("reset valid", 32'(bus.out_valid), 32'(0));

    @(negedge clk);
    rst_n = 1'b1;

    step(1'b1, 1'b1, 6'd12, 6'd12, "s1 add");
    step(1'b1, 1'b0, 6'd0,  6'd6,  "s2 pass0");
    step(1'b1, 1'b0, 6'd5,  6'd9,  "s2 pass5");
    step(1'b1, 1'b1, 6'd8,  6'd10, "s3 add");
    step(1'b1, 1'b1, 6'd40, 6'd30, "s4 wrap");
    step(1'b0, 1'b1, 6'd3,  6'd3,  "s5 hold");
    step(1'b0, 1'b0, 6'd17, 6'd1,  "s5 hold2");
    step(1'b1, 1'b1, 6'd63, 6'd1,  "wrap to zero");
    step(1'b1, 1'b0, 6'd63, 6'd63, "pass clears carry");
    step(1'b1, 1'b1, 6'd63, 6'd63, "max add");
    for (int i = 0; i < 8; i++) begin
      step(1'b1, 1'($urandom_range(0, 1)), 6'($urandom), 6'($urandom), "b2b rand");
    end

    // Mid-stream async reset while out_m6 is non-zero.
    step(1'b1, 1'b1, 6'd20, 6'd20, "pre reset");
    @(negedge clk);
    bus.in_valid       = 1'b1;
    bus.in_and         = 1'b1;
    bus.in_buf1_adder1 = 6'd7;
    bus.in_shft        = 6'd7;
    #2;
    rst_n = 1'b0;
    #1;
    check("async rst m6", 32'(bus.out_m6), 32'(0));
    check("async rst carry", 32'(bus.out_carry), 32'(0));
    check("async rst valid", 32'(bus.out_valid), 32'(0));
    sb_q.delete();
    held = '0;
    @(posedge clk);
    #1;
    check("in rst m6", 32'(bus.out_m6), 32'(0));
    check("in rst valid", 32'(bus.out_valid), 32'(0));
    @(negedge clk);
    rst_n = 1'b1;
    step(1'b1, 1'b1, 6'd17, 6'd5, "post reset");
    step(1'b1, 1'b1, 6'd33, 6'd33, "post reset wrap");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/adder_2.md
ADDER_2 -- requirements
Module: adder_2

Interface
REQ-001 The parameter WIDTH, default 6, SHALL set the data width of all operand and result ports.
REQ-002 Port clk, input, 1 bit: SHALL be the single clock; all state updates on its rising edge.
REQ-003 Port rst_n, input, 1 bit: SHALL be the reset, asynchronous and active-low.
REQ-004 Port in_valid, input, 1 bit: SHALL indicate that the operands and select are valid this cycle.
REQ-005 Port in_buf1_adder1, input, WIDTH bits: SHALL carry the base operand (incremented PC from pipeline buffer 1).
REQ-006 Port in_shft, input, WIDTH bits: SHALL carry the shifted branch offset operand.
REQ-007 Port in_and, input, 1 bit: SHALL carry the branch-taken select (branch AND zero).
REQ-008 Port out_m6, output, WIDTH bits: SHALL carry the registered selected next-address result.
REQ-009 Port out_valid, output, 1 bit: SHALL indicate that out_m6 holds a new result.
REQ-010 Port out_carry, output, 1 bit: SHALL carry the registered carry-out of the addition.

Function
REQ-011 When in_and=1, the result SHALL be (in_buf1_adder1 + in_shft) mod 2^WIDTH, unsigned.
REQ-012 When in_and=0, the result SHALL be in_buf1_adder1 unchanged (pass-through), and out_carry SHALL be 0.
REQ-013 The sum SHALL be computed at WIDTH+1 bits; bit WIDTH SHALL drive out_carry when in_and=1; overflow wraps with no saturation.
REQ-014 Latency SHALL be exactly one clock: the inputs sampled at edge N SHALL appear on out_m6, out_carry and out_valid after edge N.
REQ-015 On an edge with in_valid=1, out_m6 and out_carry SHALL load the new result and out_valid SHALL be 1.
REQ-016 On an edge with in_valid=0, out_m6 and out_carry SHALL hold their previous values and out_valid SHALL be 0.
REQ-017 There SHALL be no backpressure; a valid input is accepted every cycle, back-to-back.
REQ-018 in_and and both operands SHALL be treated as unsigned, with no sign extension inside the block.
REQ-019 There SHALL be no combinational path from any input to any output.

Reset
REQ-020 While rst_n=0, out_m6 SHALL be 0, out_carry SHALL be 0 and out_valid SHALL be 0, immediately and independent of clk.
REQ-021 Reset asserted mid-stream SHALL discard the in-flight result.
REQ-022 The first edge after rst_n deasserts SHALL behave per REQ-015/REQ-016.

Structure
REQ-023 A shared package adder2_pkg SHALL hold the WIDTH default constant and the result width constant (WIDTH+1).
REQ-024 The adder SHALL be one sub-module, adder_2_core: a purely combinational WIDTH-bit ripple-carry adder with carry-out.
REQ-025 The select mux and output registers SHALL reside in adder_2.

Verification
REQ-026 Scenario 1: valid=1, in_and=1, a=001100, b=001100 -> one cycle later out_m6=011000, carry=0, out_valid=1.
REQ-027 Scenario 2: valid=1, in_and=0, a=000000, b=000110 -> out_m6=000000; then in_and=0, a=000101, b=001001 -> out_m6=000101.
REQ-028 Scenario 3: valid=1, in_and=1, a=001000, b=001010 -> out_m6=010010, carry=0.
REQ-029 Scenario 4 (wrap): in_and=1, a=101000 (40), b=011110 (30) -> out_m6=000110, carry=1.
REQ-030 Scenario 5: after a valid result, drive in_valid=0 with new operands -> out_m6 held, out_valid=0.
REQ-031 Scenario 6: assert rst_n=0 between clock edges while out_m6 is non-zero -> all outputs 0 immediately; the next valid input after release produces the correct result one cycle later.
